// File: rtl/frame_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tx_pkg
//  Purpose  : Shared types and helpers for the frame transmit sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package frame_tx_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Widest byte the checksum helper handles; callers cast to their own width
  localparam int MAX_BYTE_W = 32;

  // Checksum byte is the inverted wrapped sum, so all bytes together sum to all-ones
  function automatic logic [MAX_BYTE_W-1:0] checksum_of(input logic [MAX_BYTE_W-1:0] sum);
    return ~sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frm_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : frm_shift_reg
//  Purpose  : Parallel-load register that shifts left one byte per strobe and
//             presents its top byte.
//  Revision : 1.0  initial release
// ============================================================================
module frm_shift_reg #(
  parameter int NUM_BYTES = 2,
  parameter int BYTE_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        shift,
  input  logic [NUM_BYTES*BYTE_W-1:0] din,
  output logic [BYTE_W-1:0]           top_byte
);

  localparam int REG_W = NUM_BYTES * BYTE_W;

  logic [REG_W-1:0] data_q;
  logic [REG_W-1:0] shifted;

  // A single-byte frame has nothing left to bring up after a shift
  generate
    if (NUM_BYTES > 1) begin : g_multi
      assign shifted = {data_q[REG_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end else begin : g_single
      assign shifted = '0;
    end
  endgenerate

  // Load has priority over shift; the two are never requested together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end else if (shift) begin
      data_q <= shifted;
    end
  end

  assign top_byte = data_q[REG_W-1 -: BYTE_W];

endmodule
`default_nettype wire

// File: rtl/frame_tx_seq.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tx_seq
//  Purpose  : Latches an N-byte frame and feeds it MSB byte first to a UART
//             transmitter over the trmt/tx_done handshake, with an optional
//             trailing checksum byte.
//  Revision : 1.0  initial release
// ============================================================================
module frame_tx_seq
  import frame_tx_pkg::*;
#(
  parameter int NUM_BYTES = 2,
  parameter int BYTE_W    = 8,
  parameter int CHKSUM_EN = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        snd_frm,
  input  logic [NUM_BYTES*BYTE_W-1:0] frm_data,
  input  logic                        tx_done,
  output logic                        trmt,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        busy,
  output logic                        frm_cmplt
);

  localparam int TOTAL = NUM_BYTES + CHKSUM_EN;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] NUM_C   = CNT_W'(NUM_BYTES);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [BYTE_W-1:0]  acc;
  logic [BYTE_W-1:0]  sr_top;
  logic [BYTE_W-1:0]  first_byte;
  logic               sr_load;
  logic               sr_shift;
  logic               chk_next;

  assign first_byte = frm_data[NUM_BYTES*BYTE_W-1 -: BYTE_W];
  assign cnt_nxt    = cnt + CNT_W'(1);
  assign sr_load    = (state == IDLE) && snd_frm;
  // Shift while the current byte is already captured in tx_data, so the next
  // byte sits on top by the time tx_done arrives
  assign sr_shift   = (state == SEND);
  assign chk_next   = (CHKSUM_EN != 0) && (cnt_nxt == NUM_C);

  frm_shift_reg #(
    .NUM_BYTES (NUM_BYTES),
    .BYTE_W    (BYTE_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sr_load),
    .shift    (sr_shift),
    .din      (frm_data),
    .top_byte (sr_top)
  );

  // Sequencer: state, byte counter, checksum accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      trmt      <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      frm_cmplt <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      trmt <= 1'b0;
      case (state)
        IDLE: begin
          if (snd_frm) begin
            cnt       <= '0;
            acc       <= '0;
            frm_cmplt <= 1'b0;
            tx_data   <= first_byte;
            trmt      <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Only data bytes contribute to the checksum
          if (cnt < NUM_C) begin
            acc <= acc + tx_data;
          end
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == TOTAL_C) begin
              frm_cmplt <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              trmt  <= 1'b1;
              state <= SEND;
              if (chk_next) begin
                tx_data <= BYTE_W'(checksum_of(MAX_BYTE_W'(acc)));
              end else begin
                tx_data <= sr_top;
              end
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_tx_seq
//  Purpose  : Self-checking bench for frame_tx_seq across four configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_tx_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [3:0]       snd;
  logic [3:0]       done;
  logic [3:0][31:0] fd;
  logic [3:0]       trmt;
  logic [3:0][7:0]  txd;
  logic [3:0]       busy;
  logic [3:0]       cmplt;

  // d0: 2 bytes plain, d1: 3 bytes + checksum, d2: 2 bytes + checksum, d3: 1 byte plain
  frame_tx_seq #(.NUM_BYTES(2), .BYTE_W(8), .CHKSUM_EN(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .snd_frm(snd[0]), .frm_data(fd[0][15:0]), .tx_done(done[0]),
    .trmt(trmt[0]), .tx_data(txd[0]), .busy(busy[0]), .frm_cmplt(cmplt[0]));
  frame_tx_seq #(.NUM_BYTES(3), .BYTE_W(8), .CHKSUM_EN(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .snd_frm(snd[1]), .frm_data(fd[1][23:0]), .tx_done(done[1]),
    .trmt(trmt[1]), .tx_data(txd[1]), .busy(busy[1]), .frm_cmplt(cmplt[1]));
  frame_tx_seq #(.NUM_BYTES(2), .BYTE_W(8), .CHKSUM_EN(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .snd_frm(snd[2]), .frm_data(fd[2][15:0]), .tx_done(done[2]),
    .trmt(trmt[2]), .tx_data(txd[2]), .busy(busy[2]), .frm_cmplt(cmplt[2]));
  frame_tx_seq #(.NUM_BYTES(1), .BYTE_W(8), .CHKSUM_EN(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .snd_frm(snd[3]), .frm_data(fd[3][7:0]), .tx_done(done[3]),
    .trmt(trmt[3]), .tx_data(txd[3]), .busy(busy[3]), .frm_cmplt(cmplt[3]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // UART model: logs every trmt byte, answers with tx_done rdelay cycles later when enabled
  logic [3:0]  resp_en;
  int          rdelay [4];
  int          rcnt   [4];
  int          lg_n   [4];
  logic [7:0]  lg     [4][8];

  initial begin
    for (int i = 0; i < 4; i++) begin
      rcnt[i] = 0;
      lg_n[i] = 0;
    end
    forever begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (resp_en[i]) done[i] = 1'b0;
        if (rcnt[i] > 0) begin
          rcnt[i]--;
          if (rcnt[i] == 0 && resp_en[i]) done[i] = 1'b1;
        end
        if (trmt[i]) begin
          if (lg_n[i] < 8) lg[i][lg_n[i]] = txd[i];
          lg_n[i]++;
          rcnt[i] = rdelay[i];
        end
      end
    end
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic [2:0]  n;
    logic [31:0] exp;   // expected bytes, first byte in [31:24]
  } vec_t;

  vec_t tbl [8];

  task automatic wait_cmplt(input int id, input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (cmplt[id] && !busy[id]) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    int id;
    id = int'(v.id);
    lg_n[id] = 0;
    fd[id]   = v.data;
    snd[id]  = 1'b1;
    step();
    snd[id]  = 1'b0;
    check("row_first_trmt", 32'(trmt[id]), 32'd1);
    check("row_first_byte", 32'(txd[id]), 32'(v.exp[31:24]));
    check("row_cmplt_clr", 32'(cmplt[id]), 32'd0);
    wait_cmplt(id, "row_timeout");
    step();
    step();
    check("row_byte_count", 32'(lg_n[id]), 32'(v.n));
    for (int k = 0; k < int'(v.n); k++) begin
      check("row_byte", 32'(lg[id][k]), 32'(v.exp[31-8*k -: 8]));
    end
  endtask

  initial begin
    tbl[0] = '{2'd0, 32'h0000A55A, 3'd2, 32'hA55A0000};
    tbl[1] = '{2'd0, 32'h00000001, 3'd2, 32'h00010000};
    tbl[2] = '{2'd1, 32'h00010203, 3'd4, 32'h010203F9};
    tbl[3] = '{2'd1, 32'h00FF0080, 3'd4, 32'hFF008080};
    tbl[4] = '{2'd2, 32'h0000FFFF, 3'd3, 32'hFFFF0100};
    tbl[5] = '{2'd2, 32'h00001234, 3'd3, 32'h1234B900};
    tbl[6] = '{2'd3, 32'h0000003C, 3'd1, 32'h3C000000};
    tbl[7] = '{2'd3, 32'h000000C3, 3'd1, 32'hC3000000};

    rdelay[0] = 20; rdelay[1] = 3; rdelay[2] = 2; rdelay[3] = 1;
    resp_en = 4'h0;
    snd = '0; done = '0; fd = '0;
    rst_n = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      check("rst_trmt", 32'(trmt[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_cmplt", 32'(cmplt[i]), 32'd0);
      check("rst_txd", 32'(txd[i]), 32'd0);
    end
    rst_n = 1'b1;
    step();

    // Stray tx_done in IDLE, then tx_done during SEND, single-byte frame
    done[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stray_trmt", 32'(trmt[3]), 32'd0);
      check("stray_busy", 32'(busy[3]), 32'd0);
    end
    done[3] = 1'b0;
    fd[3] = 32'h3C;
    snd[3] = 1'b1;
    step();
    snd[3] = 1'b0;
    check("one_trmt", 32'(trmt[3]), 32'd1);
    check("one_byte", 32'(txd[3]), 32'h3C);
    done[3] = 1'b1;
    step();
    done[3] = 1'b0;
    check("send_done_busy", 32'(busy[3]), 32'd1);
    check("send_done_cmplt", 32'(cmplt[3]), 32'd0);
    done[3] = 1'b1;
    step();
    done[3] = 1'b0;
    check("one_cmplt", 32'(cmplt[3]), 32'd1);
    check("one_busy", 32'(busy[3]), 32'd0);
    check("one_no_trmt", 32'(trmt[3]), 32'd0);

    // Two-byte frame with 20-cycle UART latency, exact handshake timing
    fd[0] = 32'hA55A;
    snd[0] = 1'b1;
    step();
    snd[0] = 1'b0;
    check("t1_trmt0", 32'(trmt[0]), 32'd1);
    check("t1_byte0", 32'(txd[0]), 32'hA5);
    check("t1_busy", 32'(busy[0]), 32'd1);
    step();
    check("t1_trmt_pulse", 32'(trmt[0]), 32'd0);
    repeat (19) step();
    done[0] = 1'b1;
    step();
    done[0] = 1'b0;
    check("t1_trmt1", 32'(trmt[0]), 32'd1);
    check("t1_byte1", 32'(txd[0]), 32'h5A);
    repeat (20) step();
    done[0] = 1'b1;
    step();
    done[0] = 1'b0;
    check("t1_cmplt", 32'(cmplt[0]), 32'd1);
    check("t1_busy_low", 32'(busy[0]), 32'd0);
    check("t1_no_trmt", 32'(trmt[0]), 32'd0);

    // Table-driven frames with the UART model answering
    resp_en = 4'hF;
    for (int r = 0; r < 8; r++) run_frame(tbl[r]);

    // snd_frm mid-frame and alongside the final tx_done are both ignored
    resp_en[1] = 1'b0;
    repeat (4) step();
    done[1] = 1'b0;
    fd[1] = 32'h010203;
    snd[1] = 1'b1;
    step();
    snd[1] = 1'b0;
    check("t4_b0", 32'(txd[1]), 32'h01);
    step();
    fd[1] = 32'hFFFFFF;
    snd[1] = 1'b1;
    step();
    snd[1] = 1'b0;
    done[1] = 1'b1;
    step();
    done[1] = 1'b0;
    check("t4_trmt1", 32'(trmt[1]), 32'd1);
    check("t4_b1", 32'(txd[1]), 32'h02);
    step();
    done[1] = 1'b1;
    step();
    done[1] = 1'b0;
    check("t4_b2", 32'(txd[1]), 32'h03);
    step();
    done[1] = 1'b1;
    step();
    done[1] = 1'b0;
    check("t4_chk", 32'(txd[1]), 32'hF9);
    step();
    fd[1] = 32'h0A0B0C;
    done[1] = 1'b1;
    snd[1] = 1'b1;
    step();
    done[1] = 1'b0;
    snd[1] = 1'b0;
    check("t4_cmplt", 32'(cmplt[1]), 32'd1);
    check("t4_busy", 32'(busy[1]), 32'd0);
    check("t4_no_trmt", 32'(trmt[1]), 32'd0);
    step();
    check("t4_still_idle", 32'(busy[1]), 32'd0);
    check("t4_cmplt_held", 32'(cmplt[1]), 32'd1);
    snd[1] = 1'b1;
    step();
    snd[1] = 1'b0;
    check("t4_cmplt_clr", 32'(cmplt[1]), 32'd0);
    check("t4_new_trmt", 32'(trmt[1]), 32'd1);
    check("t4_new_b0", 32'(txd[1]), 32'h0A);
    resp_en[1] = 1'b1;
    wait_cmplt(1, "t4_new_timeout");
    check("t4_new_chk", 32'(txd[1]), 32'hDE);

    // Reset between first and second tx_done
    resp_en[2] = 1'b0;
    repeat (4) step();
    done[2] = 1'b0;
    fd[2] = 32'hFFFF;
    snd[2] = 1'b1;
    step();
    snd[2] = 1'b0;
    check("t5_b0", 32'(txd[2]), 32'hFF);
    step();
    done[2] = 1'b1;
    step();
    done[2] = 1'b0;
    check("t5_trmt1", 32'(trmt[2]), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_rst_trmt", 32'(trmt[2]), 32'd0);
    check("t5_rst_busy", 32'(busy[2]), 32'd0);
    check("t5_rst_cmplt", 32'(cmplt[2]), 32'd0);
    check("t5_rst_txd", 32'(txd[2]), 32'd0);
    done[2] = 1'b1;
    step();
    done[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_stray_trmt", 32'(trmt[2]), 32'd0);
      check("t5_stray_busy", 32'(busy[2]), 32'd0);
    end
    resp_en[2] = 1'b1;
    run_frame(tbl[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
